bitwise_logic_unit: RTL and testbench
=====================================

BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the transaction counter width in bits, legal range 1..32.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-007 The block SHALL have port op, input, 3 bits: operation select, encoded per REQ-013.
REQ-008 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result registers hold an unconsumed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumes the result this cycle.
REQ-011 The block SHALL have port y, output, WIDTH bits: the registered result.
REQ-012 The block SHALL have port xact_cnt, output, CNT_W bits: the count of results consumed since reset.

Function
REQ-013 The block SHALL encode op per bit i as: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT a, 7 pass a; b is ignored for op 6 and op 7.
REQ-014 The block SHALL accept an input when in_valid and in_ready are both 1 at a clock edge.
REQ-015 The block SHALL drive in_ready = !out_valid || out_ready, combinationally, with no combinational path from in_valid to in_ready.
REQ-016 On acceptance, the block SHALL register y = f(op,a,b) and set out_valid = 1 at that edge, giving a latency of 1 cycle.
REQ-017 The block SHALL treat a cycle with out_valid and out_ready both 1 as a consumption; if no acceptance happens in the same cycle, out_valid SHALL clear at that edge.
REQ-018 On simultaneous consumption and acceptance, the block SHALL replace y with the new result and keep out_valid at 1, sustaining one result per cycle with no bubble.
REQ-019 While out_valid = 1 and out_ready = 0, the block SHALL hold y and every registered output stable.
REQ-020 The block SHALL increment xact_cnt by 1 on each consumption.
REQ-021 When xact_cnt is at all-ones, a consumption SHALL wrap xact_cnt to 0 without saturating.
REQ-022 The block SHALL leave y and xact_cnt unchanged while idle (in_valid = 0 and out_valid = 0).

Reset
REQ-023 When rst = 1 at a clock edge, the block SHALL drive out_valid = 0, y = 0, xact_cnt = 0 and eq = 0, overriding any simultaneous acceptance or consumption.
REQ-024 During reset, in_ready SHALL follow REQ-015, reading 1 once out_valid is 0; inputs offered while rst = 1 SHALL be discarded.
REQ-025 If reset is asserted while a result is pending, that result SHALL be dropped and SHALL NOT be counted.

Configuration
REQ-026 The macro BLU_EQ_FLAG_EN SHALL control an extra output port eq, output, 1 bit.
REQ-027 When BLU_EQ_FLAG_EN is defined, eq SHALL be registered alongside y and equal the reduction AND of ~(a^b), i.e. a == b, for every op.
REQ-028 When BLU_EQ_FLAG_EN is defined, eq SHALL follow the same hold and reset rules as y.
REQ-029 When BLU_EQ_FLAG_EN is undefined, port eq and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package blu_pkg SHALL hold the 3-bit op enumeration (OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_NOTA, OP_PASSA) and the default WIDTH and CNT_W constants.
REQ-031 The block SHALL contain exactly one sub-module, blu_op_core: purely combinational, WIDTH-parameterised, mapping op, a and b to the result.
REQ-032 The top level SHALL hold the handshake register, the result and eq registers, and the counter.

Verification
REQ-033 Bench scenario, truth table: WIDTH=4, a=4'b0011, b=4'b0101, each op 0..7 with out_ready=1 -> y = 0001, 0111, 0110, 1001, 1110, 1000, 1100, 0011, each one cycle after acceptance.
REQ-034 Bench scenario, backpressure: out_ready=0 for 5 cycles after one acceptance -> in_ready=0, y is stable, out_valid=1 and xact_cnt is unchanged; a new input is refused until out_ready=1.
REQ-035 Bench scenario, throughput: in_valid=1 and out_ready=1 for 10 consecutive cycles -> 10 results with no gaps and xact_cnt=10.
REQ-036 Bench scenario, wrap: CNT_W=4, 17 consumptions -> xact_cnt reads 15 after the 15th, 0 after the 16th and 1 after the 17th.
REQ-037 Bench scenario, reset mid-operation: rst=1 while out_valid=1 -> out_valid=0, y=0 and xact_cnt=0 at the next edge, and the dropped result is not counted.
REQ-038 Bench scenario, equality flag: with BLU_EQ_FLAG_EN defined, a=b=8'hA5 -> eq=1, and a=8'hA5, b=8'hA4 -> eq=0; the build without the macro has no eq port.

Source files
------------

// File: rtl/blu_pkg.sv
// Shared definitions for the bitwise logic unit: operation encoding and
// default parameter values used by bitwise_logic_unit and blu_op_core.
package blu_pkg;

    // Operation select; b is ignored by OP_NOTA and OP_PASSA.
    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_XNOR  = 3'd3,
        OP_NAND  = 3'd4,
        OP_NOR   = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    localparam int BLU_WIDTH_DEF = 8;
    localparam int BLU_CNT_W_DEF = 16;

endpackage

// File: rtl/blu_op_core.sv
// Purely combinational operation core: maps op, a and b to the result,
// one bit lane at a time, for any WIDTH.
module blu_op_core
    import blu_pkg::*;
#(
    parameter int WIDTH = BLU_WIDTH_DEF
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select the bitwise function; the default arm only exists so an
    // unknown select still produces a defined value.
    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_NOTA:  y = ~a;
            OP_PASSA: y = a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit with a valid/ready handshake on both sides,
// one-cycle latency, full throughput and a wrapping count of consumed results.
// Optional equality flag output eq is built when BLU_EQ_FLAG_EN is defined.
module bitwise_logic_unit
    import blu_pkg::*;
#(
    parameter int WIDTH = BLU_WIDTH_DEF,
    parameter int CNT_W = BLU_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
`ifdef BLU_EQ_FLAG_EN
    output logic             eq,
`endif
    output logic [CNT_W-1:0] xact_cnt
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] core_y;
    logic             accept;
    logic             consume;
`ifdef BLU_EQ_FLAG_EN
    logic             eq_q, eq_d;
`endif

    blu_op_core #(
        .WIDTH (WIDTH)
    ) u_op_core (
        .op (op),
        .a  (a),
        .b  (b),
        .y  (core_y)
    );

    // Handshake qualifiers; in_ready depends only on the output stage so
    // there is no path from in_valid back to in_ready.
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        consume  = out_valid_q && out_ready;
    end

    // Next state: load on accept (also covers consume+accept with no bubble),
    // drop valid on a bare consume, otherwise hold everything.
    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
`ifdef BLU_EQ_FLAG_EN
        eq_d        = eq_q;
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            y_d         = core_y;
`ifdef BLU_EQ_FLAG_EN
            eq_d        = (a == b);
`endif
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
        if (consume) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset overrides any same-cycle accept or consume,
    // so a pending result is dropped without being counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            cnt_q       <= '0;
`ifdef BLU_EQ_FLAG_EN
            eq_q        <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
`ifdef BLU_EQ_FLAG_EN
            eq_q        <= eq_d;
`endif
        end
    end

    // Output mapping.
    always_comb begin
        out_valid = out_valid_q;
        y         = y_q;
        xact_cnt  = cnt_q;
`ifdef BLU_EQ_FLAG_EN
        eq        = eq_q;
`endif
    end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit. Two instances: a 4-bit one with
// a 4-bit counter (truth table, counter wrap) and a default 8/16 one.
module tb_bitwise_logic_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic       s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic       s_in_ready, s_out_valid, s_eq;
    logic [2:0] s_op = '0;
    logic [3:0] s_a = '0, s_b = '0, s_y, s_cnt;
    // default instance
    logic        d_in_valid = 1'b0, d_out_ready = 1'b0;
    logic        d_in_ready, d_out_valid, d_eq;
    logic [2:0]  d_op = '0;
    logic [7:0]  d_a = '0, d_b = '0, d_y;
    logic [15:0] d_cnt;

    int total = 0;
    int bad   = 0;

    // Per-op truth table indexed by {a_i, b_i}.
    logic [3:0] tt_tab [0:7] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001,
                                 4'b0111, 4'b0001, 4'b0011, 4'b1100};
    // Expected 4-bit results for a=0011, b=0101, ops 0..7.
    logic [3:0] exp_tt [0:7] = '{4'b0001, 4'b0111, 4'b0110, 4'b1001,
                                 4'b1110, 4'b1000, 4'b1100, 4'b0011};

    bitwise_logic_unit #(.WIDTH(4), .CNT_W(4)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op(s_op), .a(s_a), .b(s_b), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .y(s_y),
`ifdef BLU_EQ_FLAG_EN
        .eq(s_eq),
`endif
        .xact_cnt(s_cnt)
    );

    bitwise_logic_unit u_dflt (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .op(d_op), .a(d_a), .b(d_b), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .y(d_y),
`ifdef BLU_EQ_FLAG_EN
        .eq(d_eq),
`endif
        .xact_cnt(d_cnt)
    );

`ifndef BLU_EQ_FLAG_EN
    assign s_eq = 1'b0;
    assign d_eq = 1'b0;
`endif

    function automatic logic [63:0] ref_op(input int op, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic [63:0] r;
        logic [3:0]  tt;
        r  = '0;
        tt = tt_tab[op];
        for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_in_valid = 1'b0; d_in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_in_valid = 1'b1; d_in_valid = 1'b1;
        s_out_ready = 1'b0; d_out_ready = 1'b0;
        s_a = 4'hF; d_a = 8'hFF; d_b = 8'hFF;
        step();
        step();
        total++; if (d_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", d_out_valid); end
        total++; if (d_y !== 8'h00) begin bad++; $display("FAIL rst_y: got %h want 00", d_y); end
        total++; if (d_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt: got %h want 0", d_cnt); end
        total++; if (d_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", d_in_ready); end
        total++; if (s_out_valid !== 1'b0 || s_y !== 4'h0) begin bad++; $display("FAIL rst_small: got v=%b y=%h want 0/0", s_out_valid, s_y); end
`ifdef BLU_EQ_FLAG_EN
        total++; if (d_eq !== 1'b0) begin bad++; $display("FAIL rst_eq: got %b want 0", d_eq); end
`endif
        rst = 1'b0;
        s_in_valid = 1'b0; d_in_valid = 1'b0;
        step();
        total++; if (d_out_valid !== 1'b0 || d_cnt !== 16'h0) begin bad++; $display("FAIL rst_discard: got v=%b cnt=%0d want 0/0", d_out_valid, d_cnt); end
    endtask

    task automatic test_truth_table();
        do_reset();
        s_a = 4'b0011; s_b = 4'b0101; s_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_in_valid = 1'b1;
            s_op = 3'(k);
            step();
            total++; if (s_out_valid !== 1'b1 || s_y !== exp_tt[k]) begin
                bad++; $display("FAIL truth_op%0d: got v=%b y=%b want 1 %b", k, s_out_valid, s_y, exp_tt[k]);
            end
        end
        s_in_valid = 1'b0;
        step();
        total++; if (s_cnt !== 4'd8 || s_out_valid !== 1'b0) begin bad++; $display("FAIL truth_cnt: got cnt=%0d v=%b want 8 0", s_cnt, s_out_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e0, e1;
        do_reset();
        d_in_valid = 1'b1; d_out_ready = 1'b0;
        d_op = 3'($urandom); d_a = 8'($urandom); d_b = 8'($urandom);
        e0 = 8'(ref_op(int'(d_op), 64'(d_a), 64'(d_b), 8));
        step();
        d_op = 3'($urandom); d_a = ~d_a; d_b = 8'($urandom);
        e1 = 8'(ref_op(int'(d_op), 64'(d_a), 64'(d_b), 8));
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (d_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d: got %b want 0", k, d_in_ready); end
            step();
            total++; if (d_out_valid !== 1'b1 || d_y !== e0 || d_cnt !== 16'd0) begin
                bad++; $display("FAIL bp_hold%0d: got v=%b y=%h cnt=%0d want 1 %h 0", k, d_out_valid, d_y, d_cnt, e0);
            end
        end
        d_out_ready = 1'b1;
        #1;
        total++; if (d_in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", d_in_ready); end
        step();
        total++; if (d_out_valid !== 1'b1 || d_y !== e1 || d_cnt !== 16'd1) begin
            bad++; $display("FAIL bp_release: got v=%b y=%h cnt=%0d want 1 %h 1", d_out_valid, d_y, d_cnt, e1);
        end
        d_in_valid = 1'b0;
        step();
        d_out_ready = 1'b0;
        d_a = 8'($urandom); d_b = 8'($urandom);
        step();
        total++; if (d_out_valid !== 1'b0 || d_y !== e1 || d_cnt !== 16'd2) begin
            bad++; $display("FAIL bp_idle: got v=%b y=%h cnt=%0d want 0 %h 2", d_out_valid, d_y, d_cnt, e1);
        end
    endtask

    task automatic test_throughput();
        logic [7:0] e;
        do_reset();
        d_out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d_in_valid = 1'b1;
            d_op = 3'($urandom); d_a = 8'($urandom); d_b = 8'($urandom);
            e = 8'(ref_op(int'(d_op), 64'(d_a), 64'(d_b), 8));
            #1;
            total++; if (d_in_ready !== 1'b1) begin bad++; $display("FAIL tput_ready%0d: got %b want 1", k, d_in_ready); end
            step();
            total++; if (d_out_valid !== 1'b1 || d_y !== e) begin
                bad++; $display("FAIL tput_res%0d: got v=%b y=%h want 1 %h", k, d_out_valid, d_y, e);
            end
        end
        d_in_valid = 1'b0;
        step();
        total++; if (d_cnt !== 16'd10 || d_out_valid !== 1'b0) begin bad++; $display("FAIL tput_cnt: got cnt=%0d v=%b want 10 0", d_cnt, d_out_valid); end
    endtask

    task automatic test_wrap();
        logic [3:0] e;
        do_reset();
        s_out_ready = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            s_in_valid = (k <= 17);
            s_op = 3'($urandom); s_a = 4'($urandom); s_b = 4'($urandom);
            step();
            e = 4'((k - 1) % 16);
            total++; if (s_cnt !== e) begin bad++; $display("FAIL wrap_after%0d: got %0d want %0d", k - 1, s_cnt, e); end
        end
        s_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_out_ready = 1'b1;
        d_in_valid = 1'b1; d_a = 8'h3C; d_b = 8'h0F; d_op = 3'd1;
        step();
        step();
        d_in_valid = 1'b0;
        step();
        d_in_valid = 1'b1; d_out_ready = 1'b0; d_op = 3'd7; d_a = 8'h5A;
        step();
        total++; if (d_cnt !== 16'd2 || d_out_valid !== 1'b1 || d_y !== 8'h5A) begin
            bad++; $display("FAIL mid_pending: got cnt=%0d v=%b y=%h want 2 1 5a", d_cnt, d_out_valid, d_y);
        end
        rst = 1'b1; d_out_ready = 1'b1;
        step();
        total++; if (d_out_valid !== 1'b0 || d_y !== 8'h00 || d_cnt !== 16'd0) begin
            bad++; $display("FAIL mid_reset: got v=%b y=%h cnt=%0d want 0 00 0", d_out_valid, d_y, d_cnt);
        end
        rst = 1'b0; d_in_valid = 1'b0;
        step();
        total++; if (d_out_valid !== 1'b0 || d_cnt !== 16'd0) begin
            bad++; $display("FAIL mid_dropped: got v=%b cnt=%0d want 0 0", d_out_valid, d_cnt);
        end
    endtask

`ifdef BLU_EQ_FLAG_EN
    task automatic test_eq_flag();
        do_reset();
        d_out_ready = 1'b1; d_in_valid = 1'b1; d_op = 3'($urandom);
        d_a = 8'hA5; d_b = 8'hA5;
        step();
        total++; if (d_eq !== 1'b1) begin bad++; $display("FAIL eq_same: got %b want 1", d_eq); end
        d_b = 8'hA4;
        step();
        total++; if (d_eq !== 1'b0) begin bad++; $display("FAIL eq_diff: got %b want 0", d_eq); end
        d_in_valid = 1'b0;
        step();
    endtask
`endif

    task automatic test_random();
        logic        mv, meq, iv, ordy, acc, con;
        logic [7:0]  my;
        logic [15:0] mcnt;
        do_reset();
        mv = 1'b0; my = '0; mcnt = '0; meq = 1'b0;
        for (int k = 0; k < 300; k++) begin
            iv   = ($urandom % 4) != 0;
            ordy = ($urandom % 3) != 0;
            d_in_valid = iv; d_out_ready = ordy;
            d_op = 3'($urandom); d_a = 8'($urandom);
            d_b = (($urandom % 4) == 0) ? d_a : 8'($urandom);
            #1;
            total++; if (d_in_ready !== (!mv || ordy)) begin
                bad++; $display("FAIL rnd_ready%0d: got %b want %b", k, d_in_ready, (!mv || ordy));
            end
            acc = iv && (!mv || ordy);
            con = mv && ordy;
            step();
            if (con) mcnt = mcnt + 16'd1;
            if (acc) begin
                mv  = 1'b1;
                my  = 8'(ref_op(int'(d_op), 64'(d_a), 64'(d_b), 8));
                meq = (d_a == d_b);
            end else if (con) begin
                mv = 1'b0;
            end
            total++; if (d_out_valid !== mv || d_y !== my || d_cnt !== mcnt) begin
                bad++; $display("FAIL rnd_state%0d: got v=%b y=%h cnt=%0d want %b %h %0d", k, d_out_valid, d_y, d_cnt, mv, my, mcnt);
            end
`ifdef BLU_EQ_FLAG_EN
            total++; if (d_eq !== meq) begin bad++; $display("FAIL rnd_eq%0d: got %b want %b", k, d_eq, meq); end
`endif
        end
        d_in_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_truth_table();
        test_backpressure();
        test_throughput();
        test_wrap();
        test_reset_mid();
`ifdef BLU_EQ_FLAG_EN
        test_eq_flag();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
